// File: rtl/booth_radix4_mul.sv
// booth_radix4_mul
// Sequential signed multiplier using radix-4 (modified) Booth recoding.
// Two multiplier bits are retired per clock, so a full N-bit product takes
// N/2 iterations after the operand-capture cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; also the start pulse.
//                Operands are captured on the first edge after release.
//   multiplicand signed operand M (N bits)
//   multiplier   signed operand Q (N bits)
//   out          signed 2N-bit product M*Q; forced to 0 while done=0
//   done         registered flag, high once out holds the final product
module booth_radix4_mul #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] out,
    output logic           done
);

    localparam int CW = $clog2(N/2);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(N/2 - 1);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]   m_q,     m_d;
    // Multiplier shift register with the implicit Q[-1] appended as bit 0;
    // bits [2:0] always hold the current Booth triple.
    logic [N:0]     q_q,     q_d;
    logic [2*N-1:0] acc_q,   acc_d;
    logic           done_q,  done_d;

    logic [N+1:0]   mext_s;
    logic [N+1:0]   pp_s;
    logic [2*N-1:0] pp_ext_s;
    logic [2*N-1:0] pp_sh_s;

    // Booth recoding of one triple into a partial product. The N+2-bit
    // width leaves room for +/-2M even when M is the most negative value.
    function automatic logic [N+1:0] booth_pp(input logic [2:0]   trip,
                                              input logic [N+1:0] mext);
        logic [N+1:0] r;
        case (trip)
            3'b001, 3'b010: r = mext;
            3'b011:         r = mext << 2'd1;
            3'b100:         r = -(mext << 2'd1);
            3'b101, 3'b110: r = -mext;
            default:        r = {(N+2){1'b0}};
        endcase
        return r;
    endfunction

    // Partial product for the current iteration, sign-extended and weighted by 4^i.
    always_comb begin
        mext_s   = {{2{m_q[N-1]}}, m_q};
        pp_s     = booth_pp(q_q[2:0], mext_s);
        pp_ext_s = {{(N-2){pp_s[N+1]}}, pp_s};
        pp_sh_s  = pp_ext_s << {cnt_q, 1'b0};
    end

    // Next-state logic for the LOAD -> CALC -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        done_d  = done_q;
        case (state_q)
            ST_LOAD: begin
                m_d     = multiplicand;
                q_d     = {multiplier, 1'b0};
                acc_d   = {(2*N){1'b0}};
                cnt_d   = {CW{1'b0}};
                done_d  = 1'b0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d = acc_q + pp_sh_s;
                q_d   = {2'b00, q_q[N:2]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CALC;
                    done_d  = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                done_d  = 1'b0;
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers; rst aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= {CW{1'b0}};
            m_q     <= {N{1'b0}};
            q_q     <= {(N+1){1'b0}};
            acc_q   <= {(2*N){1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    // The product is only exposed once complete; intermediate sums read as 0.
    always_comb begin
        done = done_q;
        if (done_q) begin
            out = acc_q;
        end else begin
            out = {(2*N){1'b0}};
        end
    end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul (N=32).
module tb_booth_radix4_mul;

    logic        clk;
    logic        rst;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] out_w;
    logic        done_w;

    int n_checks = 0;
    int n_fail   = 0;

    booth_radix4_mul #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out          (out_w),
        .done         (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count clock edges since rst release, capture the
    // operands on the first one, and expose the exact product from edge 17 on.
    int          mcnt = 0;
    logic [31:0] m_lat = 32'd0;
    logic [31:0] q_lat = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
        end else begin
            if (mcnt == 0) begin
                m_lat <= multiplicand;
                q_lat <= multiplier;
            end
            if (mcnt < 17) mcnt <= mcnt + 1;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic [63:0] exp_out;
        logic        exp_done;
        exp_done = (mcnt >= 17);
        exp_out  = exp_done ? 64'(longint'($signed(m_lat)) * longint'($signed(q_lat))) : 64'd0;
        chk("cyc_done", {63'd0, done_w}, {63'd0, exp_done});
        chk("cyc_out", out_w, exp_out);
    end

    // Pulse rst for one cycle with the operands applied, then count edges to done.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          output logic [63:0] res, output int edges);
        @(posedge clk); #2;
        multiplicand = m;
        multiplier   = q;
        rst          = 1'b1;
        @(posedge clk); #2;
        rst   = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_w) break;
        end
        chk("done_seen", {63'd0, done_w}, 64'd1);
        res = out_w;
    endtask

    logic [63:0] res;
    int          edges;
    logic [31:0] a, b;

    initial begin
        rst          = 1'b1;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", {63'd0, done_w}, 64'd0);
        chk("reset_out", out_w, 64'd0);

        run_op(32'd3, 32'd5, res, edges);
        chk("3x5", res, 64'h0000_0000_0000_000F);
        chk("3x5_latency", 64'(edges), 64'd17);

        run_op(32'hFFFF_FFF9, 32'd6, res, edges);
        chk("m7x6", res, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("m7x6_latency", 64'(edges), 64'd17);
        #1;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_out", out_w, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("hold_done", {63'd0, done_w}, 64'd1);

        run_op(32'h8000_0000, 32'h8000_0000, res, edges);
        chk("minxmin", res, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, edges);
        chk("m1xm1", res, 64'h0000_0000_0000_0001);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, res, edges);
        chk("maxxmin", res, 64'hC000_0000_8000_0000);

        // Abort a 12345 * -2 multiply mid-flight with an asynchronous rst.
        @(posedge clk); #2;
        multiplicand = 32'd12345;
        multiplier   = 32'hFFFF_FFFE;
        rst          = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst          = 1'b1;
        multiplicand = 32'h0001_0000;
        multiplier   = 32'h0001_0000;
        #1;
        chk("abort_done", {63'd0, done_w}, 64'd0);
        chk("abort_out", out_w, 64'd0);
        @(posedge clk); #2;
        rst   = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_w) break;
        end
        chk("restart_latency", 64'(edges), 64'd17);
        chk("restart_out", out_w, 64'h0000_0001_0000_0000);

        run_op(32'd0, 32'hDEAD_BEEF, res, edges);
        chk("0xdb", res, 64'd0);
        chk("0xdb_latency", 64'(edges), 64'd17);
        run_op(32'hDEAD_BEEF, 32'd0, res, edges);
        chk("dbx0", res, 64'd0);
        chk("dbx0_latency", 64'(edges), 64'd17);

        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom;
            run_op(a, b, res, edges);
            chk("rand_prod", res, 64'(longint'($signed(a)) * longint'($signed(b))));
            chk("rand_latency", 64'(edges), 64'd17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
